// File: rtl/regfile_bram.sv
// Dual-read, byte-or-pair-write register file held in block RAM pair-words.
// Write-first forwarding through a one-entry bypass; a clear sequencer zeroes the RAM after reset.
module regfile_bram #(
  parameter int NREGS          = 32,
  parameter int WIDTH          = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NREGS)-1:0]   a,
  input  logic [$clog2(NREGS)-1:0]   b,
  output logic [2*WIDTH-1:0]         Ra,
  output logic [WIDTH-1:0]           Rb,
  input  logic                       write,
  input  logic                       write_word,
  input  logic [$clog2(NREGS)-1:0]   d,
  input  logic [2*WIDTH-1:0]         Rd,
  output logic                       ready,
  output logic                       err
);

  localparam int AW     = $clog2(NREGS);
  localparam int NWORDS = NREGS / 2;
  localparam int WW     = AW - 1;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;

  state_t              state;
  logic [WW-1:0]       cnt;

  logic [2*WIDTH-1:0]  mem_a [NWORDS];
  logic [2*WIDTH-1:0]  mem_b [NWORDS];
  logic [2*WIDTH-1:0]  ram_a_q, ram_b_q;

  logic                we, we_lo, we_hi, misaligned;
  logic [WW-1:0]       wr_word;
  logic [2*WIDTH-1:0]  wr_data;

  logic                bp_valid, bp_lo, bp_hi;
  logic [WW-1:0]       bp_word;
  logic [2*WIDTH-1:0]  bp_data;

  logic [WW-1:0]       a_word_q, b_word_q;
  logic                a_odd_q, b_odd_q;
  logic [WIDTH-1:0]    a_lo, a_hi, b_lo, b_hi;

  // Write port arbitration: the clear sequencer owns the RAM until RUN.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    we         = 1'b0;
    we_lo      = 1'b0;
    we_hi      = 1'b0;
    misaligned = 1'b0;
    wr_word    = '0;
    wr_data    = '0;
    if (reset) begin
      if (state == ST_CLEAR) begin
        we      = 1'b1;
        we_lo   = 1'b1;
        we_hi   = 1'b1;
        wr_word = cnt;
      end else if (state == ST_RUN && write) begin
        we         = 1'b1;
        wr_word    = d[AW-1:1];
        we_lo      = !d[0];
        we_hi      = d[0] || write_word;
        misaligned = write_word && d[0];
        wr_data    = {(write_word && !d[0]) ? Rd[2*WIDTH-1:WIDTH] : Rd[WIDTH-1:0],
                      Rd[WIDTH-1:0]};
      end
    end
  end

  // NOTE: block RAM contents cannot be reset; zeroing is done by the clear sequencer instead.
  always_ff @(posedge clk) begin
    if (we_lo) begin
      mem_a[wr_word][WIDTH-1:0] <= wr_data[WIDTH-1:0];
      mem_b[wr_word][WIDTH-1:0] <= wr_data[WIDTH-1:0];
    end
    if (we_hi) begin
      mem_a[wr_word][2*WIDTH-1:WIDTH] <= wr_data[2*WIDTH-1:WIDTH];
      mem_b[wr_word][2*WIDTH-1:WIDTH] <= wr_data[2*WIDTH-1:WIDTH];
    end
    ram_a_q  <= mem_a[a[AW-1:1]];
    ram_b_q  <= mem_b[b[AW-1:1]];
    a_word_q <= a[AW-1:1];
    a_odd_q  <= a[0];
    b_word_q <= b[AW-1:1];
    b_odd_q  <= b[0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_RESET;
      cnt      <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      bp_valid <= 1'b0;
      bp_lo    <= 1'b0;
      bp_hi    <= 1'b0;
      bp_word  <= '0;
      bp_data  <= '0;
    end else begin
      err      <= misaligned;
      // Clear writes also pass through the bypass so a read on the last clear edge sees zero.
      bp_valid <= we;
      if (we) begin
        bp_lo   <= we_lo;
        bp_hi   <= we_hi;
        bp_word <= wr_word;
        bp_data <= wr_data;
      end
      case (state)
        ST_RESET: begin
          cnt <= '0;
          if (CLEAR_ON_RESET != 0) begin
            state <= ST_CLEAR;
          end else begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == WW'(NWORDS - 1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN:  ;
        default: state <= ST_RESET;
      endcase
    end
  end

  assign a_lo = (bp_valid && bp_lo && bp_word == a_word_q) ? bp_data[WIDTH-1:0]       : ram_a_q[WIDTH-1:0];
  assign a_hi = (bp_valid && bp_hi && bp_word == a_word_q) ? bp_data[2*WIDTH-1:WIDTH] : ram_a_q[2*WIDTH-1:WIDTH];
  assign b_lo = (bp_valid && bp_lo && bp_word == b_word_q) ? bp_data[WIDTH-1:0]       : ram_b_q[WIDTH-1:0];
  assign b_hi = (bp_valid && bp_hi && bp_word == b_word_q) ? bp_data[2*WIDTH-1:WIDTH] : ram_b_q[2*WIDTH-1:WIDTH];

  always_comb begin
    Ra = '0;
    Rb = '0;
    if (state == ST_RUN) begin
      Ra = a_odd_q ? {{WIDTH{1'b0}}, a_hi} : {a_hi, a_lo};
      Rb = b_odd_q ? b_hi : b_lo;
    end
  end

endmodule

// File: doc/regfile_bram.md
# regfile_bram

Parametrised successor to the byte/pair register file of the CPU core. It holds NREGS registers of WIDTH bits in a block RAM organised as NREGS/2 pair-words, with two read ports (pair-capable A, single-register B) and one byte-or-pair write port. It adds three things the previous block lacks: full write-to-read forwarding for pair writes, a hardware clear sequencer (block RAM cannot be reset), and a `ready` handshake to the core. It sits between the decode stage, which drives read addresses, and the writeback stage, which drives the write port.

## Interface
Parameters:
- `NREGS`, 32: register count; must be a power of two and at least 4.
- `WIDTH`, 8: bits per register.
- `CLEAR_ON_RESET`, 1: when 1, zero the whole file after reset; when 0, the file holds whatever the RAM contains.
- Derived: `AW = $clog2(NREGS)`; `NWORDS = NREGS/2`.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `reset` in 1: synchronous, active-low. `reset==0` at a posedge puts the block in reset.
- `a` in AW: port A register address; may be odd.
- `b` in AW: port B register address.
- `Ra` out 2*WIDTH: port A pair read data, registered.
- `Rb` out WIDTH: port B read data, registered.
- `write` in 1: write strobe.
- `write_word` in 1: 1 means a pair write, 0 means a single-register write.
- `d` in AW: write register address.
- `Rd` in 2*WIDTH: write data. A byte write uses `Rd[WIDTH-1:0]`.
- `ready` out 1: high when the file accepts writes and returns valid reads.
- `err` out 1: one-cycle pulse marking a misaligned pair write.

## Operation
- **Storage.** Two identical RAM copies (A and B), each NWORDS × 2·WIDTH, with per-half byte enables. Every write goes to both copies. Register r is stored in word r>>1, in the upper half if r[0]=1.
- **Port A read.**
  - Even `a`: `Ra = {R[a+1], R[a]}`.
  - Odd `a`: `Ra = {0, R[a]}`, i.e. the upper WIDTH bits are zero.
- **Port B read.** `Rb = R[b]`.
- **Writes.**
  - `write & !write_word`: write `Rd[WIDTH-1:0]` to R[d] (one half only).
  - `write & write_word` with even `d`: write `R[d] = Rd[WIDTH-1:0]` and `R[d+1] = Rd[2W-1:W]`.
  - `write & write_word` with odd `d`: the write is misaligned. Perform a byte write of `Rd[WIDTH-1:0]` to R[d] only, and pulse `err` on the following cycle.
- **Forwarding.**
  - A one-entry bypass register latches the word address, both half-enables and the data of every accepted write.
  - Output halves whose register matches the bypass entry take the bypass data; all other halves take the RAM output.
  - This makes reads write-first and hides the RAM's read-old-data-during-write behaviour. Pair writes must be handled correctly on both halves.
- **State machine: RESET → CLEAR → RUN.**
  - RESET (`reset==0`): `ready=0`, `Ra=0`, `Rb=0`, `err=0`, clear counter = 0, bypass invalid.
  - CLEAR (entered on the first posedge with `reset==1`, only if `CLEAR_ON_RESET=1`):
    - Write zero to word `cnt` in both copies on each cycle, then `cnt++`.
    - After word NWORDS-1 is written, go to RUN. CLEAR lasts NWORDS cycles.
    - External writes are ignored: no RAM update, no bypass update, no `err`.
    - `Ra` and `Rb` read 0.
  - With `CLEAR_ON_RESET=0`, go from RESET straight to RUN.
  - RUN: `ready=1`; normal operation.
- **Reset mid-CLEAR.** Asserting `reset` during CLEAR aborts the sequence. The next release restarts it at word 0.

## Timing
- **Read latency: 1 cycle.** Addresses sampled at posedge N produce `Ra`/`Rb` valid after posedge N. These values are held until posedge N+1.
- **Read visibility.** A read sampled at edge N reflects every accepted write sampled at an edge ≤ N, including the same edge N.
- **Write-then-read.** A byte write to R[5] at edge N followed by a pair read of A=4 at edge N+1 returns the new R[5] in the upper half. The value comes from the RAM or from the bypass, depending on the port.
- **`ready` rise.**
  - `CLEAR_ON_RESET=1`: `ready` rises after the posedge that completes clear word NWORDS-1, which is NWORDS+1 edges after the first edge with `reset==1`.
  - `CLEAR_ON_RESET=0`: `ready` rises after that first edge.
- **`err`.** `err` is high for exactly the cycle after the misaligned write's edge.
- **`ready` in RUN.** `ready` never drops in RUN except on reset.
- **Address wrap.** Wrap-around cannot occur: odd `a` never reads R[a+1], and odd `d` never writes R[d+1].

## Test plan
- **Reset/clear.** Preload the RAM with 0xA5, hold `reset=0` for 3 cycles, then release. Required: `ready=0` for 17 edges (NREGS=32), then 1. Every register reads 0, and `Ra`/`Rb`=0 throughout clear.
- **Same-edge forwarding.** In RUN, byte write d=7, Rd=0x3C while reading A=6 and B=7 on the same edge. Required: next cycle `Ra[15:8]=0x3C`, `Rb=0x3C`, `Ra[7:0]` = old R[6].
- **Pair write and odd reads.** Pair write d=20, Rd=0xBEEF. Then read A=20 → 0xBEEF; A=21 → 0x00BE; B=20 → 0xEF; B=21 → 0xBE.
- **Misaligned pair write.** Pair write d=9, Rd=0x1234. Required: `err`=1 for one cycle, R[9]=0x34, R[10] unchanged.
- **Writes ignored during clear.** Issue a write during CLEAR at word 3 (d=0, Rd=0x55). Required: no `err`, and after `ready` R[0]=0.
- **Reset mid-clear and back-to-back writes.** Assert `reset` at clear word 5, release, and verify a full NWORDS-cycle clear. Then perform back-to-back writes to the same word on consecutive edges (pair 0x1111, then byte hi 0x22) and read A=0 on the second edge. Required: `Ra=0x2211`.
